// File: rtl/data_mem_rr_pkg.sv
// data_mem_rr_pkg: shared types, default sizes and helpers for data_mem_rr.
//   mem_req_t  : request bundle {we, addr, wdata, be} at default widths
//   mem_rsp_t  : response bundle {rdata, err} at default widths
//   is_aligned : true when the byte-offset bits of an address are zero
package data_mem_rr_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 2560;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     wdata;
    logic [DEF_DATA_W/8-1:0]   be;
  } mem_req_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } mem_rsp_t;

  // Only the low byte of the address is needed: off_w never exceeds 8
  // (a 256-byte word would be the widest supported).
  function automatic logic is_aligned(input logic [7:0] addr_lo,
                                      input int unsigned off_w);
    logic [7:0] mask;
    mask = 8'((32'd1 << off_w) - 32'd1);
    return (addr_lo & mask) == 8'd0;
  endfunction

endpackage

// File: rtl/data_mem_rr_if.sv
// data_mem_rr_if: valid/ready request/response bus of data_mem_rr.
//   request : req_valid, req_ready, req_we, req_addr, req_wdata, req_be
//   response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   master  : the requester (core load/store path or testbench)
//   slave   : the memory
interface data_mem_rr_if
  import data_mem_rr_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_rr_rsp_fifo.sv
// rsp_fifo: synchronous FIFO holding responses that could not be handed
// straight to the requester.
//   clk, rst_n          : clock, synchronous active-low reset (pointers only)
//   push, push_data     : enqueue (ignored when full)
//   pop, pop_data       : dequeue (ignored when empty); pop_data shows head
//   full, empty         : occupancy flags
module rsp_fifo
  import data_mem_rr_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = mem_rsp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    pop_data = mem_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_rr.sv
// data_mem_rr: single-port byte-addressed data memory with valid/ready
// request/response handshakes, byte write strobes, RD_LAT-cycle read
// pipeline, in-order response buffering and error responses.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (control state only; storage kept)
//   bus    : data_mem_rr_if slave (req_* in, rsp_* out, req_ready out)
//   rd_cnt, wr_cnt, err_cnt : saturating accept counters, present only when
//            DATA_MEM_RR_PERF_CNT_EN is defined
module data_mem_rr
  import data_mem_rr_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_rr_if.slave  bus
`ifdef DATA_MEM_RR_PERF_CNT_EN
  ,
  output logic [31:0]   rd_cnt,
  output logic [31:0]   wr_cnt,
  output logic [31:0]   err_cnt
`endif
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(BE_W);
  localparam int unsigned RSP_DEPTH = RD_LAT + 1;
  localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int unsigned MEM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic                req_ready;
  logic                accept;
  logic                req_err;
  logic [ADDR_W-1:0]   word_idx;
  logic [MEM_AW-1:0]   mem_idx;

  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

  logic [RD_LAT-1:0]   vld_q, vld_d;
  rsp_t                rsp_q [RD_LAT];
  rsp_t                rsp_d [RD_LAT];

  logic                pipe_vld;
  rsp_t                pipe_rsp;
  rsp_t                fifo_head;
  rsp_t                rsp_sel;
  logic                rsp_valid;
  logic                rsp_hs;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic [CNT_W-1:0]    outs_q, outs_d;

  // Request decode and accept. Capping outstanding requests at the FIFO
  // depth means every response always has a slot, so none can be lost.
  always_comb begin
    req_ready = rst_n && (outs_q < CNT_W'(RSP_DEPTH));
    accept    = bus.req_valid && req_ready;
    word_idx  = bus.req_addr >> OFF_W;
    mem_idx   = word_idx[MEM_AW-1:0];
    req_err   = !is_aligned(bus.req_addr[7:0], OFF_W) ||
                (word_idx >= ADDR_W'(DEPTH_WORDS));
  end

  // Stage 0 captures the storage read at the accept edge; writes and errors
  // ride the same pipeline with zero data so responses stay in order.
  always_comb begin
    vld_d          = '0;
    vld_d[0]       = accept;
    rsp_d[0].err   = req_err;
    rsp_d[0].rdata = (!req_err && !bus.req_we) ? mem_q[mem_idx] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      rsp_d[i] = rsp_q[i-1];
    end
  end

  // ---- pipeline stage boundary: request -> stages 0..RD_LAT-1 ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    rsp_q <= rsp_d;
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (bus.req_be[k]) mem_q[mem_idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  // Response steering: the pipeline output bypasses an empty FIFO. If the
  // bypassed response is not taken it is pushed, so the FIFO head shows the
  // same value next cycle and rsp_* stay stable under backpressure.
  always_comb begin
    pipe_vld  = vld_q[RD_LAT-1];
    pipe_rsp  = rsp_q[RD_LAT-1];
    rsp_valid = !fifo_empty || pipe_vld;
    rsp_sel   = fifo_empty ? pipe_rsp : fifo_head;
    rsp_hs    = rsp_valid && bus.rsp_ready;
    fifo_pop  = !fifo_empty && bus.rsp_ready;
    fifo_push = pipe_vld && !(fifo_empty && bus.rsp_ready) && !fifo_full;
    outs_d    = outs_q + CNT_W'(accept) - CNT_W'(rsp_hs);
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (pipe_rsp),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---- pipeline stage boundary: stage RD_LAT-1 / FIFO -> response ----
  always_ff @(posedge clk) begin
    if (!rst_n) outs_q <= '0;
    else        outs_q <= outs_d;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? rsp_sel.rdata : '0;
  assign bus.rsp_err   = rsp_valid ? rsp_sel.err   : 1'b0;

`ifdef DATA_MEM_RR_PERF_CNT_EN
  logic [31:0] rd_cnt_q,  rd_cnt_d;
  logic [31:0] wr_cnt_q,  wr_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // An erroring request counts only as an error, never as a read or write.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (req_err)          err_cnt_d = sat_inc(err_cnt_q);
      else if (bus.req_we)  wr_cnt_d  = sat_inc(wr_cnt_q);
      else                  rd_cnt_d  = sat_inc(rd_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_rr.sv
// tb_data_mem_rr: directed self-checking bench for data_mem_rr with
// RD_LAT=1 (two-entry response buffering). Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_data_mem_rr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  data_mem_rr_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef DATA_MEM_RR_PERF_CNT_EN
  logic [31:0] rd_cnt, wr_cnt, err_cnt;
`endif

  data_mem_rr #(
    .DATA_W      (32),
    .DEPTH_WORDS (2560),
    .ADDR_W      (32),
    .RD_LAT      (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef DATA_MEM_RR_PERF_CNT_EN
    ,
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt),
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int waited;
    waited        = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    while (!bus.req_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, "_vld"},  {63'd0, bus.rsp_valid}, 64'd1);
    chk({tag, "_data"}, {32'd0, bus.rsp_rdata}, {32'd0, rdata});
    chk({tag, "_err"},  {63'd0, bus.rsp_err},   {63'd0, err});
  endtask

  initial begin
    int  acc;
    logic stale;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("rst_rsp_err",   {63'd0, bus.rsp_err},   64'd0);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);

    // 1: full write then read, response one cycle after accept
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    chk_rsp("t1_wr", 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000);
    chk_rsp("t1_rd", 32'hDEADBEEF, 1'b0);

    // 2: byte strobes, and be=0 is a no-op that still responds
    issue(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    chk_rsp("t2_wr_be", 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000);
    chk_rsp("t2_rd_be", 32'hDEADAAEF, 1'b0);
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    chk_rsp("t2_wr_be0", 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000);
    chk_rsp("t2_rd_be0", 32'hDEADAAEF, 1'b0);
    tick();
    chk("idle_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);

    // 3: backpressure, fill then drain in order
    issue(1'b1, 32'h0, 32'h11111111, 4'b1111);
    issue(1'b1, 32'h4, 32'h22222222, 4'b1111);
    issue(1'b1, 32'h8, 32'h33333333, 4'b1111);
    tick();
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.req_ready) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'(4 * i);
        tick();
        bus.req_valid = 1'b0;
        acc++;
      end
    end
    chk("t3_accepts", 64'(acc), 64'd2);
    chk("t3_ready_low", {63'd0, bus.req_ready}, 64'd0);
    chk_rsp("t3_head", 32'h11111111, 1'b0);
    tick();
    tick();
    tick();
    chk_rsp("t3_head_stable", 32'h11111111, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    chk_rsp("t3_second", 32'h22222222, 1'b0);
    tick();
    chk("t3_drained", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t3_ready_back", {63'd0, bus.req_ready}, 64'd1);

    // 4: errors
    issue(1'b0, 32'h12, 32'h0, 4'b0000);
    chk_rsp("t4_misalign_rd", 32'h0, 1'b1);
    issue(1'b1, 32'h2800, 32'h55555555, 4'b1111);
    chk_rsp("t4_oor_wr", 32'h0, 1'b1);
    issue(1'b1, 32'h1, 32'h66666666, 4'b1111);
    chk_rsp("t4_misalign_wr", 32'h0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 4'b0000);
    chk_rsp("t4_rd0_unchanged", 32'h11111111, 1'b0);
    issue(1'b1, 32'h27FC, 32'hCAFEF00D, 4'b1111);
    chk_rsp("t4_last_wr", 32'h0, 1'b0);
    issue(1'b0, 32'h27FC, 32'h0, 4'b0000);
    chk_rsp("t4_last_rd", 32'hCAFEF00D, 1'b0);

    // 5: back-to-back, one request and one response per cycle
    issue(1'b1, 32'h20, 32'h12345678, 4'b1111);
    chk_rsp("t5_wr", 32'h0, 1'b0);
    chk("t5_ready1", {63'd0, bus.req_ready}, 64'd1);
    issue(1'b0, 32'h20, 32'h0, 4'b0000);
    chk_rsp("t5_raw", 32'h12345678, 1'b0);
    issue(1'b1, 32'h24, 32'h9ABCDEF0, 4'b1111);
    chk_rsp("t5_wr2", 32'h0, 1'b0);
    issue(1'b0, 32'h24, 32'h0, 4'b0000);
    chk_rsp("t5_raw2", 32'h9ABCDEF0, 1'b0);
    chk("t5_ready2", {63'd0, bus.req_ready}, 64'd1);
    tick();

    // 6: reset with two responses outstanding
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 4'b0000);
    issue(1'b0, 32'h4, 32'h0, 4'b0000);
    chk("t6_pending", {63'd0, bus.rsp_valid}, 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t6_rst_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("t6_rst_ready", {63'd0, bus.req_ready}, 64'd0);
`ifdef DATA_MEM_RR_PERF_CNT_EN
    chk("t6_rd_cnt0",  {32'd0, rd_cnt},  64'd0);
    chk("t6_wr_cnt0",  {32'd0, wr_cnt},  64'd0);
    chk("t6_err_cnt0", {32'd0, err_cnt}, 64'd0);
`endif
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    stale         = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid) stale = 1'b1;
    end
    chk("t6_no_stale", {63'd0, stale}, 64'd0);
    chk("t6_ready", {63'd0, bus.req_ready}, 64'd1);
    issue(1'b0, 32'h0, 32'h0, 4'b0000);
    chk_rsp("t6_persist", 32'h11111111, 1'b0);
`ifdef DATA_MEM_RR_PERF_CNT_EN
    chk("t6_rd_cnt1", {32'd0, rd_cnt}, 64'd1);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_rr.md
Name: data_mem_rr

Overview:
Parametrised single-port data memory with a valid/ready request/response interface. It is the next generation of the flat 32-bit behavioural RAM and adds byte-address decoding, byte write strobes, configurable read latency, in-order response buffering with backpressure, and an error response. It sits between the core's load/store path (LOAD/STORE ops) and backing storage, and also serves as the testbench instruction/data memory.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
DEPTH_WORDS, 2560, number of DATA_W words (2560 x 32 bit = 10 kB).
ADDR_W, 32, byte-address width.
RD_LAT, 1, cycles from request accept to data at the storage pipeline output; legal range 1..4.
RSP_DEPTH (localparam), RD_LAT+1, response FIFO entries and maximum outstanding requests.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when valid&&ready.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_be  in  DATA_W/8  byte write enables; ignored for reads.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when valid&&ready.
rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 during reset and 1 in the first cycle after. The pipeline, FIFO and outstanding counter are cleared. Memory contents are not reset.
- Reset asserted mid-operation: all in-flight and queued responses are discarded, and no stale response appears after reset.
- Word index: req_addr >> log2(DATA_W/8).
- Error condition:
  - misaligned: low byte-offset bits are nonzero;
  - out of range: word index >= DEPTH_WORDS.
  - Effect: no storage access; response carries err=1 and rdata=0.
- Writes: at the accept edge, each byte lane with req_be[k]=1 is updated and other lanes are unchanged. be=0 is legal, is a no-op, and still produces a response.
- Every accepted request (read, write or error) produces exactly one response. Responses are strictly in order.
- Outstanding counter:
  - increments on accept and decrements on response handshake; both in the same cycle leaves it unchanged;
  - req_ready = (outstanding < RSP_DEPTH). This guarantees the FIFO never overflows, so no response is ever dropped.
- Latency:
  - a request accepted at cycle T reaches the pipeline output at T+RD_LAT;
  - if the FIFO is empty it is presented on rsp_* in that same cycle (bypass); otherwise it is enqueued behind older entries.
  - Writes and errors pass through the same RD_LAT pipeline to preserve ordering.
- Read-after-write: a read accepted at T+1 returns the data written by a write accepted at T. Reads never observe later writes.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_* hold stable.
- One request per cycle; the interface is single port.

Optional Feature:
DATA_MEM_RR_PERF_CNT_EN.
- Defined: adds output ports rd_cnt, wr_cnt, err_cnt (32 bits each).
  - Each increments on accept of a read, a write, or an erroring request respectively (an erroring request counts only in err_cnt).
  - Counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: the ports and logic are absent, with no behavioural change.

Decomposition:
- Package data_mem_rr_pkg holds:
  - typedef structs mem_req_t {we, addr, wdata, be} and mem_rsp_t {rdata, err};
  - constants for default DATA_W and DEPTH_WORDS;
  - an alignment-check function.
- One natural sub-module: rsp_fifo, a synchronous FIFO of mem_rsp_t with DEPTH parameter, push/pop, full/empty and rst_n, instantiated with RSP_DEPTH.

Test Plan:
1. Write addr 0x10, data 0xDEADBEEF, be=1111, then read 0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid exactly RD_LAT cycles after the read accept.
2. Write addr 0x10, data 0x0000AA00, be=0010, then read -> 0xDEADAAEF. Write with be=0000 -> read is unchanged.
3. Hold rsp_ready=0 and issue reads at 0x0,0x4,0x8,... -> req_ready drops after exactly RSP_DEPTH accepts. Release rsp_ready -> responses arrive in issue order with rsp_* stable while stalled.
4. Read 0x12 -> err=1, rdata=0. Write to byte address 4*DEPTH_WORDS -> err=1, and a subsequent read of 0x0 is unchanged.
5. Back-to-back write 0x20=0x12345678 then read 0x20 on consecutive cycles -> 0x12345678. Accept and response handshakes in the same cycle keep throughput at 1 per cycle with rsp_ready=1.
6. Assert rst_n=0 for one cycle with 2 responses outstanding -> rsp_valid=0 after the edge, no stale responses afterwards, and memory data persists across the reset. With DATA_MEM_RR_PERF_CNT_EN defined, the counters read 0 after reset.
